// File: rtl/ring_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ring_count_decoder
// Purpose  : Receive-side checker for a rotating one-hot ring counter.
//            Acquires lock after LOCK_CNT consecutive correct right-rotations.
//            While locked it reports the binary index of the hot bit.
//            It flags in-lock violations with a one-cycle err pulse.
//            It keeps a saturating count of those violations.
// Ports    : clk          - clock, all state changes on rising edge
//            rst          - asynchronous reset, active low
//            in_valid     - ring_in is sampled on this edge
//            ring_in      - WIDTH-bit ring pattern under test
//            index        - hot-bit position of last accepted in-lock sample
//            index_valid  - one-cycle pulse, index updated
//            locked       - checker is in LOCKED
//            err          - one-cycle pulse on an in-lock violation
//            err_count    - saturating count of err pulses
// Revision : 1.0 - initial release
// ============================================================================
module ring_count_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8,
  localparam int IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  // The step counter only needs to reach LOCK_CNT.
  localparam int            SCW    = $clog2(LOCK_CNT + 1);
  localparam logic [IW-1:0] c_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_last_pos;
  logic [SCW-1:0]    r_step_cnt;
  logic [IW-1:0]     r_index;
  logic              r_index_valid;
  logic              r_err;
  logic [ERRW-1:0]   r_err_count;

  state_t            w_state_nxt;
  logic [IW-1:0]     w_last_pos_nxt;
  logic [SCW-1:0]    w_step_cnt_nxt;
  logic [IW-1:0]     w_index_nxt;
  logic              w_index_valid_nxt;
  logic              w_err_nxt;
  logic [ERRW-1:0]   w_err_count_nxt;

  logic              w_onehot;
  logic [IW-1:0]     w_pos;
  logic [IW-1:0]     w_expected;
  logic              w_step_ok;
  logic [SCW-1:0]    w_step_inc;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot   = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  // The ring rotates right, so the hot bit moves down one place, 0 wraps to top.
  assign w_expected = (r_last_pos == '0) ? c_LAST : (r_last_pos - IW'(1));
  assign w_step_ok  = w_onehot && (w_pos == w_expected);
  assign w_step_inc = r_step_cnt + SCW'(1);

  // Position of the highest set bit; only meaningful when w_onehot is true.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        w_pos = IW'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_last_pos_nxt    = r_last_pos;
    w_step_cnt_nxt    = r_step_cnt;
    w_index_nxt       = r_index;
    w_index_valid_nxt = 1'b0;
    w_err_nxt         = 1'b0;
    w_err_count_nxt   = r_err_count;

    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_onehot) begin
            w_last_pos_nxt = w_pos;
            w_step_cnt_nxt = '0;
            w_state_nxt    = SYNC;
          end
        end

        SYNC: begin
          if (!w_onehot) begin
            w_state_nxt = HUNT;
          end else if (w_step_ok) begin
            w_last_pos_nxt = w_pos;
            w_step_cnt_nxt = w_step_inc;
            if (w_step_inc == SCW'(LOCK_CNT)) begin
              w_state_nxt       = LOCKED;
              w_index_nxt       = w_pos;
              w_index_valid_nxt = 1'b1;
            end
          end else begin
            // A wrong step restarts the count from the new position.
            w_last_pos_nxt = w_pos;
            w_step_cnt_nxt = '0;
          end
        end

        LOCKED: begin
          if (w_step_ok) begin
            w_last_pos_nxt    = w_pos;
            w_index_nxt       = w_pos;
            w_index_valid_nxt = 1'b1;
          end else begin
            // index keeps its last good value across a violation.
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
            if (r_err_count != '1) begin
              w_err_count_nxt = r_err_count + ERRW'(1);
            end
          end
        end

        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= HUNT;
      r_last_pos    <= '0;
      r_step_cnt    <= '0;
      r_index       <= '0;
      r_index_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_pos    <= w_last_pos_nxt;
      r_step_cnt    <= w_step_cnt_nxt;
      r_index       <= w_index_nxt;
      r_index_valid <= w_index_valid_nxt;
      r_err         <= w_err_nxt;
      r_err_count   <= w_err_count_nxt;
    end
  end

  assign index       = r_index;
  assign index_valid = r_index_valid;
  assign locked      = (r_state == LOCKED);
  assign err         = r_err;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
